// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD character-RAM arbiter.
// Holds the arbiter state enum, RAM geometry defaults and counter width.
package lcd_pkg;

  localparam int LCD_ADDR_W = 11;
  localparam int LCD_DATA_W = 8;
  localparam int WR_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SCAN  = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_rr_picker.sv
// One-hot picker over an eligible vector, searching from ptr_i+1 upward.
// Ports: elig_i, ptr_i in; grant_o (one-hot), idx_o, any_o out.
module lcd_rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic             found;
  logic [PTR_W-1:0] sel;

  // Wrap-around scan: the slot after the pointer gets first look,
  // the pointer slot itself is considered last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sel     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sel = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (!found && elig_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
      end
    end
  end

  assign any_o = |elig_i;

endmodule

// File: rtl/lcd_text_arbiter.sv
// Character RAM arbiter: scan reads while den=1, queued writes in blanking.
// Ports: CLK, RST_n, den, scan_addr/scan_data, req/wr_addr/wr_data/ack,
//        mem_addr/mem_wdata/mem_we/mem_rdata, wr_count, clr_count.
// Build option: LCD_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module lcd_text_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = LCD_ADDR_W,
  parameter int DATA_W = LCD_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    den,
  input  logic [ADDR_W-1:0]       scan_addr,
  output logic [DATA_W-1:0]       scan_data,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [WR_COUNT_W-1:0]   wr_count,
  input  logic                    clr_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  lcd_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [WR_COUNT_W-1:0]   wr_count_q, wr_count_d;

  logic [N_REQ-1:0]        elig;
  logic [N_REQ-1:0]        grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    any_elig;
  logic [PTR_W-1:0]        ptr;

  // A request already acked this cycle is still high; masking it
  // keeps the same write from being granted twice.
  assign elig = req & ~ack_q;

`ifdef LCD_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_d == WRITE) ptr_d = grant_idx;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  // Pointer parked on the top slot makes the search start at index 0.
  assign ptr = PTR_W'(N_REQ - 1);
`endif

  lcd_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .elig_i  (elig),
    .ptr_i   (ptr),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_elig)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      den:              state_d = SCAN;
      !den && any_elig: state_d = WRITE;
      !den && !any_elig: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    case (state_d)
      SCAN: begin
        mem_addr_d = scan_addr;
      end
      WRITE: begin
        mem_addr_d  = wr_addr[grant_idx*ADDR_W +: ADDR_W];
        mem_wdata_d = wr_data[grant_idx*DATA_W +: DATA_W];
        ack_d       = grant;
      end
      default: begin
      end
    endcase
  end

  // The write currently on the port is counted at the edge it lands.
  always_comb begin
    wr_count_d = wr_count_q;
    if (clr_count)
      wr_count_d = '0;
    else if (state_q == WRITE && wr_count_q != '1)
      wr_count_d = wr_count_q + 1'b1;
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack       = ack_q;
  assign wr_count  = wr_count_q;
  assign scan_data = mem_rdata;

endmodule
